// File: rtl/cdb_arbiter_pkg.sv
// Shared execution-stage definitions: write-back unit indices and the CDB bus record.
`ifndef DataWidth
`define DataWidth 32
`endif

package exe;

  localparam int UNITS  = 6;
  localparam int UNIT_W = 3;

  localparam logic [UNIT_W-1:0] UNIT_ALU  = 3'd0;
  localparam logic [UNIT_W-1:0] UNIT_DIV  = 3'd1;
  localparam logic [UNIT_W-1:0] UNIT_FPU  = 3'd2;
  localparam logic [UNIT_W-1:0] UNIT_FDIV = 3'd3;
  localparam logic [UNIT_W-1:0] UNIT_CSR  = 3'd4;
  localparam logic [UNIT_W-1:0] UNIT_MEM  = 3'd5;

  localparam int CDB_DATA_W = `DataWidth;
  localparam int CDB_TAG_W  = 6;

  typedef struct packed {
    logic                  valid_;
    logic [CDB_DATA_W-1:0] data;
    logic [CDB_TAG_W-1:0]  tag;
    logic                  exp;
    logic [UNIT_W-1:0]     unit;
  } CdbBus_t;

  localparam CdbBus_t CDB_RESET = '{valid_: 1'b1, data: '0, tag: '0, exp: 1'b0, unit: '0};

  // Index reached by stepping 'off' places upward from 'base' with wrap at n.
  function automatic logic [UNIT_W-1:0] wrap_idx(input logic [UNIT_W-1:0] base,
                                                 input int off, input int n);
    return UNIT_W'((int'(base) + off) % n);
  endfunction

endpackage

// File: rtl/cdb_arb_pick.sv
// Combinational picker: first requester found searching upward (with wrap) from start.
module cdb_arb_pick #(
  parameter int N = exe::UNITS
) (
  input  logic [N-1:0]           req,
  input  logic [exe::UNIT_W-1:0] start,
  output logic [N-1:0]           gnt,
  output logic [exe::UNIT_W-1:0] idx,
  output logic                   any
);
  import exe::*;

  logic [UNIT_W-1:0] cand;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the block infers a latch.
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 0; i < N; i++) begin
      cand = wrap_idx(start, i, N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB write-back arbiter: one grant per cycle among six units, registered CDB output.
// Define CDB_RR_EN for round-robin selection; otherwise fixed priority, highest index wins.
`ifndef DataWidth
`define DataWidth 32
`endif

module cdb_arbiter #(
  parameter int DATA  = `DataWidth,
  parameter int TAG   = 6,
  parameter int UNITS = exe::UNITS
) (
  input  logic                       clk,
  input  logic                       reset_,
  input  logic [UNITS-1:0]           wb_req_,
  input  logic [UNITS-1:0][DATA-1:0] wb_data,
  input  logic [UNITS-1:0][TAG-1:0]  wb_tag,
  input  logic [UNITS-1:0]           wb_exp,
  output logic [UNITS-1:0]           wb_ack_,
  input  logic                       cdb_stall,
  output logic                       cdb_valid_,
  output logic [DATA-1:0]            cdb_data,
  output logic [TAG-1:0]             cdb_tag,
  output logic                       cdb_exp,
  output logic [2:0]                 cdb_unit
);
  import exe::*;

  logic [UNITS-1:0]  req;
  logic [UNITS-1:0]  pick_req;
  logic [UNITS-1:0]  pick_gnt;
  logic [UNITS-1:0]  gnt;
  logic [UNIT_W-1:0] pick_start;
  logic [UNIT_W-1:0] pick_idx;
  logic [UNIT_W-1:0] win_idx;
  logic              pick_any;
  logic              grant;
  CdbBus_t           cdb_d;
  CdbBus_t           cdb_q;

  assign req = ~wb_req_;

  cdb_arb_pick #(.N(UNITS)) u_pick (
    .req   (pick_req),
    .start (pick_start),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .any   (pick_any)
  );

`ifdef CDB_RR_EN
  logic [UNIT_W-1:0] rr_ptr_d;
  logic [UNIT_W-1:0] rr_ptr_q;

  assign pick_req   = req;
  assign pick_start = rr_ptr_q;
  assign gnt        = pick_gnt;
  assign win_idx    = pick_idx;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (win_idx == UNIT_MEM) ? UNIT_ALU : win_idx + UNIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (!reset_) rr_ptr_q <= UNIT_ALU;
    else         rr_ptr_q <= rr_ptr_d;
  end
`else
  // Mirroring the vector makes the picker's upward search land on the highest index first.
  always_comb begin
    pick_req = '0;
    gnt      = '0;
    for (int i = 0; i < UNITS; i++) begin
      pick_req[i] = req[UNITS-1-i];
      gnt[i]      = pick_gnt[UNITS-1-i];
    end
  end

  assign pick_start = UNIT_ALU;
  assign win_idx    = UNIT_W'(UNITS-1) - pick_idx;
`endif

  // Reset and stall both suppress the grant, so the ack vector and the CDB load stay in step.
  assign grant   = reset_ && !cdb_stall && pick_any;
  assign wb_ack_ = grant ? ~gnt : '1;

  always_comb begin
    cdb_d        = cdb_q;
    cdb_d.valid_ = 1'b1;
    if (grant) begin
      cdb_d.valid_ = 1'b0;
      cdb_d.data   = CDB_DATA_W'(wb_data[win_idx]);
      cdb_d.tag    = CDB_TAG_W'(wb_tag[win_idx]);
      cdb_d.exp    = wb_exp[win_idx];
      cdb_d.unit   = win_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) cdb_q <= CDB_RESET;
    else         cdb_q <= cdb_d;
  end

  assign cdb_valid_ = cdb_q.valid_;
  assign cdb_data   = DATA'(cdb_q.data);
  assign cdb_tag    = TAG'(cdb_q.tag);
  assign cdb_exp    = cdb_q.exp;
  assign cdb_unit   = cdb_q.unit;

endmodule
